// File: rtl/ldbuf_stream_arb_3_to_1.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ldbuf_stream_arb_3_to_1                                                     |
// | Round-robin packet arbiter merging IFM/WGT/BIAS streams into one tagged one. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module ldbuf_stream_arb_3_to_1 #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [1:0]  IFM        = 2'b01,
  parameter logic [1:0]  WGT        = 2'b10,
  parameter logic [1:0]  BIAS       = 2'b11,
  parameter int          MAX_BURST  = 256,
  parameter int          CNT_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifm_valid,
  input  logic [DATA_WIDTH-1:0] ifm_data,
  input  logic                  ifm_last,
  output logic                  ifm_ready,
  input  logic                  wgt_valid,
  input  logic [DATA_WIDTH-1:0] wgt_data,
  input  logic                  wgt_last,
  output logic                  wgt_ready,
  input  logic                  bias_valid,
  input  logic [DATA_WIDTH-1:0] bias_data,
  input  logic                  bias_last,
  output logic                  bias_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_sel,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  burst_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BURST - 1);

  // Channel indices 0/1/2 = IFM/WGT/BIAS; wraps modulo 3.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] code_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return IFM;
      2'd1:    return WGT;
      default: return BIAS;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [1:0]              rr_q, rr_d;
  logic [1:0]              gnt_q, gnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [1:0]              out_sel_q, out_sel_d;
  logic                    out_last_q, out_last_d;
  logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
  logic                    burst_err_q, burst_err_d;

  logic [2:0]              in_valid;
  logic                    pick_ok;
  logic [1:0]              pick_idx;
  logic [1:0]              cand;
  logic                    g_valid;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    g_last;
  logic                    in_rdy;
  logic                    fire;
  logic                    release_now;

  assign in_valid = {bias_valid, wgt_valid, ifm_valid};

  // Highest-priority candidate is evaluated last so it wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = rr_q;
    cand     = rr_q;
    for (int k = 2; k >= 0; k--) begin
      cand = rr_add(rr_q, 2'(k));
      if (in_valid[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_last  = 1'b0;
    case (gnt_q)
      2'd0: begin g_valid = ifm_valid;  g_data = ifm_data;  g_last = ifm_last;  end
      2'd1: begin g_valid = wgt_valid;  g_data = wgt_data;  g_last = wgt_last;  end
      2'd2: begin g_valid = bias_valid; g_data = bias_data; g_last = bias_last; end
      default: ;
    endcase
  end

  assign in_rdy      = !out_valid_q || out_ready;
  assign fire        = (state_q == BUSY) && g_valid && in_rdy;
  assign release_now = g_last || (beat_cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_sel_d   = 2'b00;
    end

    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          gnt_d   = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (fire) begin
          out_valid_d = 1'b1;
          out_data_d  = g_data;
          out_sel_d   = code_of(gnt_q);
          out_last_d  = release_now;
          if (release_now) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_d       = rr_add(gnt_q, 2'd1);
            // A burst cut without the source's own last marker is sticky-flagged.
            if (!g_last) burst_err_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 2'd0;
      gnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'b00;
      out_last_q  <= 1'b0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign ifm_ready  = (state_q == BUSY) && (gnt_q == 2'd0) && in_rdy;
  assign wgt_ready  = (state_q == BUSY) && (gnt_q == 2'd1) && in_rdy;
  assign bias_ready = (state_q == BUSY) && (gnt_q == 2'd2) && in_rdy;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
  assign beat_cnt  = beat_cnt_q;
  assign burst_err = burst_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ldbuf_stream_arb_3_to_1.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ldbuf_stream_arb_3_to_1                                                  |
// | Directed + random bench with a packet-level arbitration model.              |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_ldbuf_stream_arb_3_to_1;

  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int CW   = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    sel;
    logic          last;
  } obeat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    v;
  logic [DW-1:0] d [3];
  logic [2:0]    l;
  logic          ifm_ready, wgt_ready, bias_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_last;
  logic          out_ready;
  logic [CW-1:0] beat_cnt;
  logic          burst_err;
  logic [2:0]    rdy;

  always #5 clk = ~clk;

  ldbuf_stream_arb_3_to_1 #(
    .DATA_WIDTH(DW), .MAX_BURST(MAXB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifm_valid(v[0]),  .ifm_data(d[0]),  .ifm_last(l[0]),  .ifm_ready(ifm_ready),
    .wgt_valid(v[1]),  .wgt_data(d[1]),  .wgt_last(l[1]),  .wgt_ready(wgt_ready),
    .bias_valid(v[2]), .bias_data(d[2]), .bias_last(l[2]), .bias_ready(bias_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .out_ready(out_ready), .beat_cnt(beat_cnt), .burst_err(burst_err)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  beat_t  src [3][$];
  obeat_t exp_q [$];
  int     pos [3];
  int     gap [3];
  int     rdy_hi [3];
  int     fire_cnt [3];
  int     ready_pct;
  bit     gaps_en;
  int     stall_left;
  int     stall_at_beat;
  int     out_cnt;
  int     bubbles;
  bit     seen_first;
  int     model_rr;
  bit     err_exp;
  bit     prev_fire;
  bit     prev_hold;
  obeat_t held;

  function automatic logic [1:0] code_of(input int c);
    if (c == 0) return 2'b01;
    if (c == 1) return 2'b10;
    return 2'b11;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_state();
    for (int c = 0; c < 3; c++) begin
      src[c].delete();
      pos[c] = 1; gap[c] = 0; rdy_hi[c] = 0; fire_cnt[c] = 0;
    end
    exp_q.delete();
    prev_fire = 0; prev_hold = 0;
    model_rr = 0; err_exp = 0;
    stall_left = 0; stall_at_beat = 0;
  endtask

  task automatic load_pkt(input int c, input int len, input logic [DW-1:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? DW'($urandom) : base + DW'(i);
      b.last = (i == len - 1);
      src[c].push_back(b);
    end
  endtask

  // Packet-level model: each grant goes to the first non-empty channel from the
  // rr pointer and lasts until the source's last beat or MAXB beats.
  task automatic predict();
    beat_t  cp [3][$];
    beat_t  b;
    obeat_t o;
    int     c, n;
    bit     done;
    for (int i = 0; i < 3; i++) cp[i] = src[i];
    while (1) begin
      c = -1;
      for (int k = 0; k < 3; k++)
        if (c < 0 && cp[(model_rr + k) % 3].size() > 0) c = (model_rr + k) % 3;
      if (c < 0) break;
      n = 0; done = 0;
      while (!done && cp[c].size() > 0) begin
        b = cp[c].pop_front();
        n++;
        done = b.last || (n == MAXB);
        o.data = b.data; o.sel = code_of(c); o.last = done;
        exp_q.push_back(o);
        if (done && !b.last) err_exp = 1;
      end
      model_rr = (c + 1) % 3;
    end
  endtask

  task automatic step();
    beat_t  b;
    obeat_t e;
    int     n;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      if (gap[c] > 0) begin
        v[c] = 1'b0; gap[c]--; d[c] = DW'($urandom); l[c] = 1'($urandom);
      end else if (src[c].size() > 0) begin
        v[c] = 1'b1; d[c] = src[c][0].data; l[c] = src[c][0].last;
      end else begin
        v[c] = 1'b0; d[c] = DW'($urandom); l[c] = 1'($urandom);
      end
    end
    if (stall_left > 0) begin
      out_ready = 1'b0; stall_left--;
    end else begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
    @(negedge clk);
    rdy = {bias_ready, wgt_ready, ifm_ready};
    chk("ready_onehot0", 64'($onehot0(rdy)), 64'd1);
    if (!out_valid) chk("sel_when_idle", 64'(out_sel), 64'd0);
    if (out_valid && !out_ready) chk("ready_blocked_on_stall", 64'(rdy), 64'd0);
    if (prev_fire) chk("fire_to_out_valid", 64'(out_valid), 64'd1);
    if (prev_hold) begin
      chk("hold_data", 64'(out_data), 64'(held.data));
      chk("hold_sel",  64'(out_sel),  64'(held.sel));
      chk("hold_last", 64'(out_last), 64'(held.last));
    end
    if (!out_valid && seen_first) bubbles++;
    if (out_valid && out_ready) begin
      n = exp_q.size();
      chk("beat_expected", 64'(n != 0), 64'd1);
      if (n != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_sel",  64'(out_sel),  64'(e.sel));
        chk("out_last", 64'(out_last), 64'(e.last));
      end
      seen_first = 1;
      out_cnt++;
      if (out_cnt == stall_at_beat) stall_left = 5;
    end
    prev_hold = out_valid && !out_ready;
    held.data = out_data; held.sel = out_sel; held.last = out_last;
    prev_fire = 0;
    for (int c = 0; c < 3; c++) begin
      if (rdy[c]) rdy_hi[c]++;
      if (v[c] && rdy[c]) begin
        prev_fire = 1;
        fire_cnt[c]++;
        b = src[c].pop_front();
        if (gaps_en && !b.last && (pos[c] % MAXB) != 0) gap[c] = $urandom_range(0, 2);
        pos[c] = b.last ? 1 : pos[c] + 1;
      end
    end
  endtask

  task automatic run(input int max_cycles);
    int cyc;
    cyc = 0; seen_first = 0; bubbles = 0; out_cnt = 0;
    while ((exp_q.size() > 0 || src[0].size() > 0 || src[1].size() > 0 || src[2].size() > 0)
           && cyc < max_cycles) begin
      step();
      cyc++;
    end
    chk("run_drained", 64'(exp_q.size()), 64'd0);
    chk("beat_cnt_after_run", 64'(beat_cnt), 64'd0);
    chk("burst_err", 64'(burst_err), 64'(err_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_out_sel"},   64'(out_sel),   64'd0);
    chk({tag, "_out_last"},  64'(out_last),  64'd0);
    chk({tag, "_beat_cnt"},  64'(beat_cnt),  64'd0);
    chk({tag, "_burst_err"}, 64'(burst_err), 64'd0);
    chk({tag, "_readies"},   64'({bias_ready, wgt_ready, ifm_ready}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; v = '0; l = '0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) d[c] = '0;
    ready_pct = 100; gaps_en = 0;
    clear_state();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Three 3-beat packets, all valid together: IFM, WGT, BIAS in order.
    load_pkt(0, 3, 32'h10, 0);
    load_pkt(1, 3, 32'h20, 0);
    load_pkt(2, 3, 32'h30, 0);
    predict();
    run(200);
    chk("rr3_bubbles", 64'(bubbles), 64'd2);

    // Single-beat IFM packet.
    for (int c = 0; c < 3; c++) rdy_hi[c] = 0;
    load_pkt(0, 1, 32'hDEADBEEF, 0);
    predict();
    run(50);
    chk("single_ifm_ready_cycles", 64'(rdy_hi[0]), 64'd1);

    // WGT 4-beat packet with a 5-cycle output stall after beat 2.
    stall_at_beat = 2;
    load_pkt(1, 4, 32'hA0, 0);
    predict();
    run(100);
    stall_at_beat = 0;

    // BIAS 6-beat packet: forced release on beat 4.
    load_pkt(2, 6, 32'hB0, 0);
    predict();
    run(100);
    chk("burst_err_forced", 64'(burst_err), 64'd1);

    // BIAS-only 2-beat packets: regranted each time with one bubble.
    load_pkt(2, 2, 32'hC0, 0);
    load_pkt(2, 2, 32'hC2, 0);
    load_pkt(2, 2, 32'hC4, 0);
    predict();
    run(100);
    chk("bias_only_bubbles", 64'(bubbles), 64'd2);

    // Move rr to BIAS, then reset while WGT is mid-packet.
    load_pkt(1, 2, 32'hD0, 0);
    predict();
    run(100);
    for (int c = 0; c < 3; c++) fire_cnt[c] = 0;
    load_pkt(1, 5, 32'hE0, 0);
    predict();
    for (int i = 0; i < 50 && fire_cnt[1] < 2; i++) step();
    chk("wgt_two_fired", 64'(fire_cnt[1]), 64'd2);
    @(posedge clk); #1;
    chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0; v = '0;
    #1 check_reset_outputs("mid_reset");
    clear_state();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    load_pkt(0, 1, 32'hF0, 0);
    load_pkt(1, 1, 32'hF1, 0);
    load_pkt(2, 1, 32'hF2, 0);
    predict();
    run(100);

    // Random traffic: random packet counts/lengths, output backpressure, valid gaps.
    gaps_en = 1;
    for (int r = 0; r < 8; r++) begin
      ready_pct = $urandom_range(30, 100);
      for (int c = 0; c < 3; c++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) load_pkt(c, $urandom_range(1, 6), '0, 1);
      end
      predict();
      run(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ldbuf_stream_arb_3_to_1.md
Name: ldbuf_stream_arb_3_to_1

Overview:
- Merges three independent load streams (IFM, WGT, BIAS) onto one tagged output stream; this is the gather-side counterpart of the 1-to-3 load demux.
- Each input is a valid/ready stream with a last marker.
- A round-robin arbiter grants one channel per packet and holds the grant until that channel's last beat is accepted.
- The output beat carries a 2-bit sel tag using the same channel codes as the demux, so the stream can be split again downstream.

Parameters:
- DATA_WIDTH, 32, width of every data bus.
- IFM, 2'b01, sel code for the IFM channel.
- WGT, 2'b10, sel code for the WGT channel.
- BIAS, 2'b11, sel code for the BIAS channel.
- MAX_BURST, 256, maximum beats per grant before forced release.
- CNT_WIDTH, 9, width of beat_cnt; must satisfy 2^CNT_WIDTH > MAX_BURST.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ifm_valid  input  1  IFM beat valid
- ifm_data  input  DATA_WIDTH  IFM beat
- ifm_last  input  1  last beat of IFM packet
- ifm_ready  output  1  IFM beat accepted this cycle when high with ifm_valid
- wgt_valid / wgt_data / wgt_last / wgt_ready  same as IFM, for WGT
- bias_valid / bias_data / bias_last / bias_ready  same as IFM, for BIAS
- out_valid  output  1  output beat valid
- out_data  output  DATA_WIDTH  output beat
- out_sel  output  2  channel code of out_data; 2'b00 when out_valid=0
- out_last  output  1  last beat of the packet, or forced-release beat
- out_ready  input  1  downstream accept
- beat_cnt  output  CNT_WIDTH  beats accepted in the current grant
- burst_err  output  1  sticky; set when a grant was force-released; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr pointer=IFM, grant=none. Outputs: out_valid=0, out_data=0, out_sel=2'b00, out_last=0, beat_cnt=0, burst_err=0, all *_ready=0.
- Reset asserted mid-packet: the held output beat is dropped and no partial state survives; arbitration restarts from IFM.
- FSM has two states.
- IDLE:
  - If any input valid, pick the first valid channel in round-robin order starting at the rr pointer, register the grant, go to BUSY.
  - No input ready in IDLE; this costs a one-cycle arbitration bubble.
  - If no input valid, stay in IDLE.
- BUSY:
  - ready of the granted channel = !out_valid || out_ready. Non-granted readies are 0.
- Input fire = granted valid && granted ready. On fire:
  - out_data <= data, out_sel <= channel code, out_valid <= 1.
  - out_last <= (in_last || beat_cnt == MAX_BURST-1).
  - beat_cnt increments.
  - Latency: input fire to out_valid is 1 cycle.
- Output handshake: out_valid=1 && out_ready=1 with no new fire clears out_valid and sets out_sel to 2'b00. Output and input fire in the same cycle: the register reloads and out_valid stays 1. Throughput is 1 beat/cycle inside a packet.
- Output is stable: out_data, out_sel and out_last do not change while out_valid=1 && out_ready=0.
- Release: on the fire of a beat with in_last=1, or of beat number MAX_BURST:
  - grant <= none, beat_cnt <= 0, rr pointer <= channel after the granted one (IFM->WGT->BIAS->IFM), state <= IDLE.
  - Forced release without in_last also sets burst_err; the channel's remaining beats form a new packet in a later grant.
- Single-beat packet: valid and last in the same beat is legal; IDLE->BUSY->IDLE, with out_last=1 on that beat.
- Input valid dropping mid-packet: the grant is held and the arbiter waits indefinitely; no other channel is served.
- Back-to-back packets on the same channel with the other channels idle: the same channel is regranted after the 1-cycle IDLE bubble.

Test Plan:
- Reset with all three valid and a 3-beat packet on each (data 0x10.., 0x20.., 0x30..) -> output order IFM, WGT, BIAS, with out_sel 01,01,01,10,10,10,11,11,11 and out_last on beats 3, 6, 9; 1 bubble between packets.
- Single IFM 1-beat packet data 0xDEADBEEF, out_ready=1 -> ifm_ready high for 1 cycle, out_valid the next cycle with out_sel=01 and out_last=1; beat_cnt returns to 0.
- WGT 4-beat packet with out_ready held 0 for 5 cycles after beat 2 -> out_data stays at beat 2, wgt_ready=0 during the stall, no beat lost or duplicated; all 4 beats delivered in order.
- MAX_BURST=4 with a BIAS packet of 6 beats and no last until beat 6 -> out_last on beat 4, burst_err=1, then a new grant; beats 5 and 6 follow with out_last on beat 6.
- Reset pulsed while a WGT packet is 2 of 5 beats in and out_valid=1 -> all outputs at reset values immediately; the next arbitration picks IFM if it is valid.
- Only BIAS valid continuously with 2-beat packets -> BIAS regranted each time; one out_valid=0 bubble per packet, sel stays 11.
